// File: rtl/envelope_decimator.sv
// ---------------------------------------------------------------------------
// envelope_decimator
//
// Purpose:
//   Turns a stream of signed FIR samples into a decimated, unsigned amplitude
//   envelope. Each output is the sum of |x| over DECIM valid input samples,
//   right-shifted by SHIFT and clipped to 16 bits.
//
//   Pipeline:
//     stage 1 : a_q <= |x|, a_vld_q <= x_valid (dropped by sync_clr)
//     stage 2 : acc_q/cnt_q accumulate; on the frame's last sample the
//               sum is scaled, clipped and presented on y with a one-cycle
//               y_valid strobe.
//
//   Stream handshake: x_valid is a qualifier only (no back-pressure). A
//   sample is consumed on every rising edge where x_valid=1 and sync_clr=0;
//   y_valid is a single-cycle strobe and y/sat hold their value between
//   strobes.
//
// Parameters:
//   DECIM  samples per output frame (2..256)
//   SHIFT  right-shift applied to the frame sum (0..10)
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   x         in   18-bit signed sample
//   x_valid   in   x carries a new sample this cycle
//   sync_clr  in   synchronous frame restart, partial frame discarded
//   y         out  16-bit unsigned envelope
//   y_valid   out  single-cycle strobe, y is new this cycle
//   sat       out  y was clipped; updated with each y_valid
// ---------------------------------------------------------------------------
module envelope_decimator #(
    parameter int DECIM = 16,
    parameter int SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [17:0] x,
    input  logic               x_valid,
    input  logic               sync_clr,
    output logic        [15:0] y,
    output logic               y_valid,
    output logic               sat
);

    localparam int            CW   = (DECIM > 2) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    // Stage 1 registers
    logic [17:0]   a_q,     a_d;
    logic          a_vld_q, a_vld_d;
    // Stage 2 registers
    logic [25:0]   acc_q,   acc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [15:0]   y_q,     y_d;
    logic          yv_q,    yv_d;
    logic          sat_q,   sat_d;

    logic [17:0]   mag;
    logic [25:0]   sum;
    logic [25:0]   scaled;
    logic          clip;

    // |x| in 18 unsigned bits: -131072 negates to 0x20000, which is exactly
    // 131072 when read as unsigned, so no wrap occurs.
    always_comb begin
        mag = x[17] ? (~$unsigned(x) + 18'd1) : $unsigned(x);
    end

    // 256 * 131072 = 2^25 fits in 26 bits, so this add never overflows.
    always_comb begin
        sum    = acc_q + {8'd0, a_q};
        scaled = sum >> SHIFT;
        clip   = |scaled[25:16];
    end

    always_comb begin
        a_d     = mag;
        a_vld_d = x_valid && !sync_clr;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        sat_d   = sat_q;
        yv_d    = 1'b0;
        // Clear has priority over a dump: the partial or just-completed
        // frame is dropped and y/sat keep their previous value.
        if (sync_clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (a_vld_q) begin
            if (cnt_q == LAST) begin
                acc_d = '0;
                cnt_d = '0;
                yv_d  = 1'b1;
                y_d   = clip ? 16'hFFFF : scaled[15:0];
                sat_d = clip;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            a_vld_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            a_vld_q <= a_vld_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            sat_q   <= sat_d;
        end
    end

    assign y       = y_q;
    assign y_valid = yv_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_envelope_decimator.sv
// ---------------------------------------------------------------------------
// tb_envelope_decimator
//
// Two instances share one stimulus stream: inst 0 uses DECIM=4/SHIFT=2,
// inst 1 uses DECIM=256/SHIFT=10. A frame-level model (running sum and
// count of valid magnitudes per instance) predicts y/y_valid/sat, and a
// compare process checks both instances on every falling edge. Directed
// cases additionally pin the strobe values to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_envelope_decimator;

  logic               clk;
  logic               rst_n;
  logic signed [17:0] x;
  logic               x_valid;
  logic               sync_clr;

  logic [15:0] dut_y  [2];
  logic        dut_yv [2];
  logic        dut_sat[2];

  int n_vec;
  int n_err;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  envelope_decimator #(.DECIM(4), .SHIFT(2)) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .x_valid  (x_valid),
    .sync_clr (sync_clr),
    .y        (dut_y[0]),
    .y_valid  (dut_yv[0]),
    .sat      (dut_sat[0])
  );

  envelope_decimator #(.DECIM(256), .SHIFT(10)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .x_valid  (x_valid),
    .sync_clr (sync_clr),
    .y        (dut_y[1]),
    .y_valid  (dut_yv[1]),
    .sat      (dut_sat[1])
  );

  // ---------------- behavioural model ----------------
  // A sample offered on edge k becomes part of its frame on edge k+1; a
  // sync_clr on edge k+1 (or on k itself) throws it away with the rest of
  // the partial frame. When DECIM samples are collected the frame's sum
  // is scaled and clipped.
  int     decim_p[2];
  int     shift_p[2];
  longint fsum   [2];
  int     fcnt   [2];
  bit     pend   [2];
  longint pmag   [2];
  int     exp_y  [2];
  bit     exp_yv [2];
  bit     exp_sat[2];
  bit     check_en;

  initial begin
    decim_p[0] = 4;   shift_p[0] = 2;
    decim_p[1] = 256; shift_p[1] = 10;
  end

  always @(posedge clk or negedge rst_n) begin
    longint s;
    longint xi;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        fsum[i] = 0; fcnt[i] = 0; pend[i] = 0; pmag[i] = 0;
        exp_y[i] = 0; exp_yv[i] = 0; exp_sat[i] = 0;
      end else begin
        exp_yv[i] = 0;
        if (sync_clr) begin
          fsum[i] = 0;
          fcnt[i] = 0;
          pend[i] = 0;
        end else begin
          if (pend[i]) begin
            fsum[i] += pmag[i];
            fcnt[i] += 1;
            if (fcnt[i] == decim_p[i]) begin
              s = fsum[i] / (64'sd1 << shift_p[i]);
              exp_sat[i] = (s > 65535);
              exp_y[i]   = (s > 65535) ? 65535 : int'(s);
              exp_yv[i]  = 1;
              fsum[i] = 0;
              fcnt[i] = 0;
            end
          end
          xi = longint'(x);
          pend[i] = x_valid;
          pmag[i] = (xi < 0) ? -xi : xi;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (dut_y[i] !== 16'(exp_y[i]) || dut_yv[i] !== exp_yv[i] ||
            dut_sat[i] !== exp_sat[i]) begin
          n_err++;
          $display("FAIL model_cmp inst%0d t=%0t: got y=%0d yv=%0b sat=%0b, want y=%0d yv=%0b sat=%0b",
                   i, $time, dut_y[i], dut_yv[i], dut_sat[i], exp_y[i], exp_yv[i], exp_sat[i]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered just after a falling edge; holds inputs for one full cycle.
  task automatic drive(input int xv, input logic v, input logic c);
    x        = 18'(xv);
    x_valid  = v;
    sync_clr = c;
    @(negedge clk);
  endtask

  task automatic check_lit(input string name, input int inst, input int ey,
                           input logic es, input int ewait);
    int waited;
    bit seen;
    waited = 0;
    seen   = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      drive(0, 1'b0, 1'b0);
      waited++;
      if (dut_yv[inst]) seen = 1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: no y_valid within 8 cycles, want y=%0d", name, ey);
    end else if (dut_y[inst] !== 16'(ey) || dut_sat[inst] !== es) begin
      n_err++;
      $display("FAIL %s: got y=%0d sat=%0b, want y=%0d sat=%0b",
               name, dut_y[inst], dut_sat[inst], ey, es);
    end
    if (ewait > 0) begin
      n_vec++;
      if (waited != ewait) begin
        n_err++;
        $display("FAIL %s_latency: strobe after %0d idle cycles, want %0d",
                 name, waited, ewait);
      end
    end
  endtask

  task automatic check_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (dut_y[i] !== 16'd0 || dut_yv[i] !== 1'b0 || dut_sat[i] !== 1'b0) begin
        n_err++;
        $display("FAIL %s inst%0d: got y=%0d yv=%0b sat=%0b, want all 0",
                 name, i, dut_y[i], dut_yv[i], dut_sat[i]);
      end
    end
  endtask

  // Reset pulse strictly between a falling and the next rising edge.
  task automatic reset_pulse(input string name);
    x_valid  = 1'b0;
    sync_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero(name);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec    = 0;
    n_err    = 0;
    check_en = 0;
    rst_n    = 1'b0;
    x        = '0;
    x_valid  = 1'b0;
    sync_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_en = 1;

    // Constant 100: first strobe one cycle after the 4th sample's cycle.
    drive(0, 1'b0, 1'b1);
    repeat (4) drive(100, 1'b1, 1'b0);
    check_lit("const100_first", 0, 100, 1'b0, 1);
    repeat (8) drive(100, 1'b1, 1'b0);
    check_lit("const100_third", 0, 100, 1'b0, 1);

    // Alternating sign: absolute values add.
    drive(0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) drive((k % 2 == 0) ? 300 : -300, 1'b1, 1'b0);
    check_lit("alt300", 0, 300, 1'b0, 1);

    // Most negative input clips, then a zero frame clears sat.
    drive(0, 1'b0, 1'b1);
    repeat (4) drive(-131072, 1'b1, 1'b0);
    check_lit("neg_full_scale", 0, 65535, 1'b1, 1);
    repeat (4) drive(0, 1'b1, 1'b0);
    check_lit("zero_after_sat", 0, 0, 1'b0, 1);

    // Gaps in x_valid are ignored.
    drive(0, 1'b0, 1'b1);
    drive(8, 1'b1, 1'b0);
    drive(9, 1'b0, 1'b0);
    drive(9, 1'b0, 1'b0);
    drive(16, 1'b1, 1'b0);
    drive(9, 1'b0, 1'b0);
    drive(24, 1'b1, 1'b0);
    drive(32, 1'b1, 1'b0);
    check_lit("gapped", 0, 20, 1'b0, 1);

    // Clear with a coincident valid sample discards both partial frame and 999.
    drive(0, 1'b0, 1'b1);
    repeat (2) drive(40, 1'b1, 1'b0);
    drive(999, 1'b1, 1'b1);
    repeat (4) drive(40, 1'b1, 1'b0);
    check_lit("clr_restart", 0, 40, 1'b0, 1);

    // Mid-frame async reset, DECIM=4 instance.
    drive(0, 1'b0, 1'b1);
    repeat (3) drive(12, 1'b1, 1'b0);
    reset_pulse("reset_mid_frame4");
    repeat (4) drive(12, 1'b1, 1'b0);
    check_lit("after_reset4", 0, 12, 1'b0, 1);

    // Mid-frame async reset, DECIM=256 instance, near full scale.
    drive(0, 1'b0, 1'b1);
    repeat (3) drive(131071, 1'b1, 1'b0);
    reset_pulse("reset_mid_frame256");
    repeat (256) drive(131071, 1'b1, 1'b0);
    check_lit("after_reset256", 1, 32767, 1'b0, 1);

    // Randomized stream checked against the model every cycle.
    for (int k = 0; k < 1500; k++) begin
      int xv;
      case ($urandom_range(0, 7))
        0:       xv = -131072;
        1:       xv = 131071;
        default: xv = int'($urandom_range(0, 262143)) - 131072;
      endcase
      drive(xv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end
    repeat (4) drive(0, 1'b0, 1'b0);

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
